// File: rtl/ps2_pkg.sv
// ps2_pkg: shared receiver state encoding and scan-code prefix constants.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;
endpackage

// File: rtl/ps2_host_rx_if.sv
// ps2_host_rx_if: received-byte and status bundle from the PS/2 receiver to the core.
interface ps2_host_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       err_parity;
    logic       err_timeout;
    logic       busy;
    logic       code_ext;
    logic       code_rel;
    modport master (output rx_data, rx_valid, err_parity, err_timeout, busy, code_ext, code_rel);
    modport slave  (input  rx_data, rx_valid, err_parity, err_timeout, busy, code_ext, code_rel);
endinterface

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: 2-FF synchroniser, stability filter and falling-edge pulse for a slow async line.
module ps2_clk_filter #(
    parameter int FILTER = 4
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic din_i,
    output logic fall_o
);
    logic [1:0] sync_q;
    logic       filt_q, filt_d, prev_q, diff, flip;
    logic [3:0] cnt_q, cnt_d;
    always_comb begin
        diff   = sync_q[1] != filt_q;
        flip   = diff && cnt_q == 4'(FILTER - 1);
        filt_d = flip ? ~filt_q : filt_q;
        cnt_d  = (diff && !flip) ? cnt_q + 4'd1 : 4'd0;
    end
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            prev_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], din_i};
            filt_q <= filt_d;
            prev_q <= filt_q;
            cnt_q  <= cnt_d;
        end
    end
    assign fall_o = prev_q & ~filt_q;
endmodule

// File: rtl/ps2_host_rx.sv
// ps2_host_rx: PS/2 device-to-host frame receiver with parity/stop check and stall timeout.
// Define PS2_RX_SCANCODE_EN to fold E0/F0 prefixes into code_ext/code_rel.
module ps2_host_rx
    import ps2_pkg::*;
#(
    parameter int FILTER  = 4,
    parameter int TIMEOUT = 2000
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_host_rx_if.master rx
);
    state_t      state_q, state_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d, data_q;
    logic        par_q, par_d;
    logic [15:0] tmo_q, tmo_d;
    logic [1:0]  dsync_q;
    logic        fall, din, good, bad, expire, take;
    logic        valid_q, errp_q, errt_q;
    ps2_clk_filter #(.FILTER(FILTER)) u_clk_filter (
        .clk_sys(clk_sys),
        .reset  (reset),
        .din_i  (ps2_clk),
        .fall_o (fall)
    );
    assign din = dsync_q[1];
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        good     = 1'b0;
        bad      = 1'b0;
        expire   = state_q != IDLE && !fall && tmo_q >= 16'(TIMEOUT - 1);
        tmo_d    = (fall || state_q == IDLE) ? 16'd0 : (tmo_q == 16'(TIMEOUT)) ? tmo_q : tmo_q + 16'd1;
        if (expire) state_d = IDLE;
        else if (fall)
            case (state_q)
                IDLE: if (!din) begin
                    state_d  = DATA;
                    bitcnt_d = '0;
                end
                DATA: begin
                    shift_d  = {din, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = din;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    good    = din && (^{shift_q, par_q});
                    bad     = !good;
                end
            endcase
    end
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
            dsync_q  <= 2'b11;
            data_q   <= '0;
            valid_q  <= 1'b0;
            errp_q   <= 1'b0;
            errt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tmo_q    <= tmo_d;
            dsync_q  <= {dsync_q[0], ps2_data};
            valid_q  <= take;
            errp_q   <= bad;
            errt_q   <= expire;
            if (take) data_q <= shift_q;
        end
    end
`ifdef PS2_RX_SCANCODE_EN
    logic ext_q, ext_d, rel_q, rel_d, cext_q, crel_q;
    // prefixes are swallowed and remembered until the code byte they qualify arrives
    always_comb begin
        ext_d = ext_q;
        rel_d = rel_q;
        take  = good && shift_q != PS2_PREFIX_EXT && shift_q != PS2_PREFIX_REL;
        if (good && shift_q == PS2_PREFIX_EXT) ext_d = 1'b1;
        if (good && shift_q == PS2_PREFIX_REL) rel_d = 1'b1;
        if (take || bad || expire) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
        end
    end
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ext_q  <= 1'b0;
            rel_q  <= 1'b0;
            cext_q <= 1'b0;
            crel_q <= 1'b0;
        end else begin
            ext_q <= ext_d;
            rel_q <= rel_d;
            if (take) begin
                cext_q <= ext_q;
                crel_q <= rel_q;
            end
        end
    end
    assign rx.code_ext = cext_q;
    assign rx.code_rel = crel_q;
`else
    assign take        = good;
    assign rx.code_ext = 1'b0;
    assign rx.code_rel = 1'b0;
`endif
    assign rx.rx_data     = data_q;
    assign rx.rx_valid    = valid_q;
    assign rx.err_parity  = errp_q;
    assign rx.err_timeout = errt_q;
    assign rx.busy        = state_q != IDLE;
endmodule
